// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter merging NUM_REQ pixel streams into one write FIFO; grant decided one cycle after request.
// FIFO_ARB_BURST_LOCK_EN: hold a grant up to BURST_LEN beats or req_last; otherwise one beat per grant.
module fifo_wr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 24,
  parameter int BURST_LEN  = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]            req_last,
  input  logic                          fifo_full,
  output logic                          fifo_wrt,
  output logic [DATA_WIDTH-1:0]         fifo_idata,
  output logic [$clog2(NUM_REQ)-1:0]    grant_id,
  output logic                          busy
);
  localparam int GW = $clog2(NUM_REQ);

  typedef enum logic {IDLE, BURST} state_t;

  state_t        state;
  logic [GW-1:0] last_grant;
  logic [GW-1:0] winner;
  logic          active;
  logic          beat;
  logic          burst_end;
  int            idx;

  // Walk offsets from far to near so the nearest valid index after last_grant wins.
  always_comb begin
    winner = last_grant;
    idx    = 0;
    for (int off = NUM_REQ; off >= 1; off--) begin
      idx = int'(last_grant) + off;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (req_valid[idx]) winner = GW'(idx);
    end
  end

  // Reset forces every output quiet even before the state register clears.
  assign active = (state == BURST) && !rst;
  assign busy   = active;

  always_comb begin
    req_ready = '0;
    if (active) req_ready[grant_id] = ~fifo_full;
  end

  assign fifo_wrt   = active & req_valid[grant_id] & ~fifo_full;
  assign fifo_idata = active ? req_data[int'(grant_id)*DATA_WIDTH +: DATA_WIDTH] : '0;
  assign beat       = fifo_wrt;

`ifdef FIFO_ARB_BURST_LOCK_EN
  logic [7:0] beat_cnt;

  assign burst_end = beat & (req_last[grant_id] | (beat_cnt == 8'(BURST_LEN - 1)));

  always_ff @(posedge clk) begin
    if (rst)                 beat_cnt <= '0;
    else if (state == IDLE)  beat_cnt <= '0;
    else if (beat)           beat_cnt <= beat_cnt + 8'd1;
  end
`else
  logic unused_cfg;
  assign unused_cfg = ^{req_last, 8'(BURST_LEN)};
  assign burst_end  = beat;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      grant_id   <= '0;
      last_grant <= GW'(NUM_REQ - 1);
    end else begin
      case (state)
        IDLE: begin
          if (|req_valid) begin
            grant_id <= winner;
            state    <= BURST;
          end
        end
        BURST: begin
          if (burst_end) begin
            state      <= IDLE;
            last_grant <= grant_id;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
